// File: rtl/mips_lsu.sv
// Load/store unit driving a single-port, word-addressed, byte-swapped data RAM.
// Optional MIPS_LSU_ALIGN_CHECK_EN: misaligned half/word requests return an error instead of being force-aligned.
module mips_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] MODIFY = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  logic [1:0]  state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] raw_q;
  logic [31:0] rdata_q;

  logic        illegal;
  logic        is_sw;
  logic [4:0]  byte_lsb;
  logic [4:0]  half_hi_lsb;
  logic [4:0]  half_lo_lsb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] merged;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  always_comb begin
    illegal = (req_size == SZ_RSVD);
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    if (req_size == SZ_HALF && req_addr[0])
      illegal = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
      illegal = 1'b1;
`endif
  end

  // Big-endian offset k sits in raw bits [8k+7:8k]; halfwords ignore addr[0] (force-aligned).
  assign byte_lsb    = {addr_q[1:0], 3'b000};
  assign half_hi_lsb = {addr_q[1], 1'b0, 3'b000};
  assign half_lo_lsb = {addr_q[1], 1'b1, 3'b000};

  assign ld_byte = data_readdata[byte_lsb +: 8];
  assign ld_half = {data_readdata[half_hi_lsb +: 8], data_readdata[half_lo_lsb +: 8]};

  always_comb begin
    case (size_q)
      SZ_BYTE: ld_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = bswap(data_readdata);
    endcase
  end

  always_comb begin
    merged = raw_q;
    if (size_q == SZ_BYTE) begin
      merged[byte_lsb +: 8] = wdata_q[7:0];
    end else begin
      merged[half_hi_lsb +: 8] = wdata_q[15:8];
      merged[half_lo_lsb +: 8] = wdata_q[7:0];
    end
  end

  assign is_sw      = we_q && (size_q == SZ_WORD);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

  always_comb begin
    data_address   = '0;
    data_read      = 1'b0;
    data_write     = 1'b0;
    data_writedata = '0;
    if (state == ACCESS || state == MODIFY)
      data_address = {addr_q[31:2], 2'b00};
    if (state == ACCESS) begin
      if (is_sw) begin
        data_write     = 1'b1;
        data_writedata = bswap(wdata_q);
      end else begin
        data_read = 1'b1;
      end
    end else if (state == MODIFY) begin
      data_write     = 1'b1;
      data_writedata = merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      raw_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= illegal;
            rdata_q <= '0;
            state   <= illegal ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= ld_data;
            state   <= RESP;
          end else if (size_q == SZ_WORD) begin
            state <= RESP;
          end else begin
            raw_q <= data_readdata;
            state <= MODIFY;
          end
        end
        MODIFY:  state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_lsu.sv
// Randomised self-checking bench for mips_lsu against a byte-array memory model.
module tb_mips_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [16];
  logic [7:0]  rb  [64];

  logic [31:0] last_rdata;
  logic [31:0] last_wdata;
  logic        last_err;

  mips_lsu dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .data_address(data_address), .data_write(data_write),
    .data_read(data_read), .data_writedata(data_writedata),
    .data_readdata(data_readdata)
  );

  always #5 clk = ~clk;

  assign data_readdata = ram[data_address[5:2]];
  always @(posedge clk)
    if (data_write) ram[data_address[5:2]] <= data_writedata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("strobe_excl", {31'h0, data_read && data_write}, 32'h0);
    if (!data_write) check("wdata_idle_zero", data_writedata, 32'h0);
  end

  function automatic logic [31:0] ref_word(input int unsigned i);
    return {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
  endfunction

  task automatic set_word(input int unsigned i, input logic [31:0] raw);
    ram[i] = raw;
    for (int unsigned k = 0; k < 4; k++) rb[4*i+k] = raw[8*k +: 8];
  endtask

  task automatic op(input bit we, input logic [1:0] size, input bit uns,
                    input logic [31:0] addr, input logic [31:0] wd);
    bit          err;
    int unsigned a;
    logic [31:0] exp_rd, exp_wd;
    int          exp_lat, exp_rds, exp_wrs, lat, rds, wrs, n;
    logic [31:0] wdat;
    bit          addr_ok, was_resp;
    logic [15:0] h;

    err = (size == 2'd3);
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    if (size == 2'd1 && addr[0]) err = 1;
    if (size == 2'd2 && addr[1:0] != 2'b00) err = 1;
`endif
    a = addr[5:0];
    if (size == 2'd1) a = a & ~32'd1;
    if (size == 2'd2) a = a & ~32'd3;
    exp_rd = '0;
    exp_wd = '0;
    if (!err && !we) begin
      case (size)
        2'd0: exp_rd = uns ? {24'h0, rb[a]} : {{24{rb[a][7]}}, rb[a]};
        2'd1: begin
          h = {rb[a], rb[a+1]};
          exp_rd = uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        default: exp_rd = {rb[a], rb[a+1], rb[a+2], rb[a+3]};
      endcase
    end else if (!err) begin
      case (size)
        2'd0: rb[a] = wd[7:0];
        2'd1: begin rb[a] = wd[15:8]; rb[a+1] = wd[7:0]; end
        default: begin
          rb[a] = wd[31:24]; rb[a+1] = wd[23:16]; rb[a+2] = wd[15:8]; rb[a+3] = wd[7:0];
        end
      endcase
      exp_wd = ref_word(a / 4);
    end
    exp_lat = err ? 1 : ((we && size != 2'd2) ? 3 : 2);
    exp_rds = (err || (we && size == 2'd2)) ? 0 : 1;
    exp_wrs = (!err && we) ? 1 : 0;

    was_resp = resp_valid;
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    if (was_resp) begin
      @(negedge clk);
      check("resp_pulse_len", {31'h0, resp_valid}, 32'h0);
    end
    n = 0;
    while (!req_ready && n < 4) begin @(negedge clk); n++; end
    check("req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

    lat = 1; rds = 0; wrs = 0; wdat = '0; addr_ok = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid) break;
      if (data_read) rds++;
      if (data_write) begin wrs++; wdat = data_writedata; end
      if ((data_read || data_write) && data_address !== {addr[31:2], 2'b00}) addr_ok = 0;
      lat++;
    end
    check("resp_valid", {31'h0, resp_valid}, 32'h1);
    check("latency", lat, exp_lat);
    check("resp_err", {31'h0, resp_err}, {31'h0, err});
    check("resp_rdata", resp_rdata, exp_rd);
    check("read_cycles", rds, exp_rds);
    check("write_cycles", wrs, exp_wrs);
    check("data_address", {31'h0, addr_ok}, 32'h1);
    if (exp_wrs == 1) check("write_word", wdat, exp_wd);
    last_rdata = resp_rdata;
    last_err   = resp_err;
    last_wdata = wdat;
  endtask

  initial begin
    reset = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    for (int unsigned i = 0; i < 16; i++) set_word(i, $urandom);
    set_word(0, 32'h78563412);
    set_word(1, 32'hAC68EEEE);

    #1;
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_data_write", {31'h0, data_write}, 32'h0);
    check("rst_data_read", {31'h0, data_read}, 32'h0);
    check("rst_data_address", data_address, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    repeat (2) @(negedge clk);
    reset = 0;

    op(0, 2'd2, 0, 32'h0, 0);  check("lw0", last_rdata, 32'h12345678);
    op(0, 2'd0, 0, 32'h4, 0);  check("lb4", last_rdata, 32'hFFFFFFEE);
    op(0, 2'd0, 1, 32'h4, 0);  check("lbu4", last_rdata, 32'h000000EE);
    op(0, 2'd1, 0, 32'h4, 0);  check("lh4", last_rdata, 32'hFFFFEEEE);
    op(0, 2'd1, 1, 32'h6, 0);  check("lhu6", last_rdata, 32'h000068AC);
    op(0, 2'd0, 0, 32'h1, 0);  check("lb1", last_rdata, 32'h00000034);
    op(0, 2'd2, 0, 32'h2, 0);
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    check("lw2_err", {31'h0, last_err}, 32'h1);
`else
    check("lw2_aligned", last_rdata, 32'h12345678);
`endif
    op(1, 2'd3, 0, 32'h0, 32'hFFFFFFFF);
    check("rsvd_err", {31'h0, last_err}, 32'h1);
    op(1, 2'd0, 0, 32'h1, 32'h000000AB); check("sb1_word", last_wdata, 32'h7856AB12);
    op(0, 2'd2, 0, 32'h0, 0);            check("lw0_after_sb", last_rdata, 32'h12AB5678);
    set_word(0, 32'h78563412);
    op(1, 2'd1, 0, 32'h2, 32'h0000BEEF); check("sh2_word", last_wdata, 32'hEFBE3412);
    op(1, 2'd2, 0, 32'h8, 32'hDEADBEEF); check("sw8_word", last_wdata, 32'hEFBEADDE);

    // Abort an SB in its read cycle with reset.
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'd0; req_unsigned = 0;
    req_addr = 32'h11; req_wdata = 32'h000000C3;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    check("abort_in_access", {31'h0, data_read}, 32'h1);
    reset = 1;
    #1;
    check("abort_data_write", {31'h0, data_write}, 32'h0);
    check("abort_data_read", {31'h0, data_read}, 32'h0);
    check("abort_data_address", data_address, 32'h0);
    check("abort_writedata", data_writedata, 32'h0);
    check("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_write", {31'h0, data_write}, 32'h0);
    end
    reset = 0;
    #1 check("abort_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    check("abort_ram_intact", ram[4], ref_word(4));

    for (int t = 0; t < 200; t++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      op(1'($urandom), sz, 1'($urandom), {$urandom_range(0, 3) == 0 ? $urandom : 32'h0} | 32'($urandom_range(0, 63)), $urandom);
    end

    @(negedge clk);
    for (int unsigned i = 0; i < 16; i++) check("final_ram", ram[i], ref_word(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
